// File: rtl/mult_red_0.sv
// Four-stage Barrett modular multiplier feeding the butterfly adder: Kyber (q=3329, AH lane delay-matched)
// or Dilithium (q=8380417), selected per word. Define MULT_RED_RANGE_CHECK_EN to add the sticky err_oor flag.
module mult_red_0 (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic        mode_in,
    input  logic [23:0] a_in,
    input  logic [23:0] w_in,
    output logic        out_valid,
    output logic        mode_out,
    output logic [23:0] res
`ifdef MULT_RED_RANGE_CHECK_EN
    ,
    output logic        err_oor
`endif
);

    localparam int unsigned KQ   = 3329;
    localparam int unsigned DQ   = 8380417;
    localparam int unsigned MU_K = 5039;
    localparam int unsigned MU_D = 8396807;

    typedef enum logic {
        MODE_KYBER     = 1'b0,
        MODE_DILITHIUM = 1'b1
    } mode_e;

    // Stage valid bits and output registers (reset).
    logic        s1_valid_q, s2_valid_q, s3_valid_q;
    logic        out_valid_q;
    mode_e       mode_out_q;
    logic [23:0] res_q;

    // Datapath registers (not reset).
    mode_e       s1_mode_q, s2_mode_q, s3_mode_q;
    logic [23:0] s1_a_q;
    logic [22:0] s1_w_q;
    logic [45:0] s2_p_q;
    logic [11:0] s2_ah_q, s3_ah_q;
    logic [24:0] s3_r0_q;

    logic [45:0] s2_p_d;
    logic [24:0] s3_r0_d;
    logic [23:0] res_d;
    logic [12:0] t_k;
    logic [23:0] t_d;
    logic [13:0] r_k;
    logic [24:0] r_d;

    // w_in[23] carries no information in either mode.
    logic unused_w_msb;
    assign unused_w_msb = w_in[23];

    // S2: raw product. Kyber only uses the low lane; AH rides alongside untouched.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        s2_p_d = '0;
        if (s1_mode_q == MODE_KYBER) begin
            s2_p_d = 46'(s1_a_q[11:0]) * 46'(s1_w_q[11:0]);
        end else begin
            s2_p_d = 46'(s1_a_q[22:0]) * 46'(s1_w_q);
        end
    end

    // S3: Barrett quotient estimate; t undershoots floor(p/q) by at most one, so r0 < 2q.
    always_comb begin
        t_k     = '0;
        t_d     = '0;
        s3_r0_d = '0;
        if (s2_mode_q == MODE_KYBER) begin
            t_k     = 13'((37'(s2_p_q[23:0]) * 37'(MU_K)) >> 24);
            s3_r0_d = 25'(s2_p_q[23:0]) - 25'(t_k) * 25'(KQ);
        end else begin
            t_d     = 24'((70'(s2_p_q) * 70'(MU_D)) >> 46);
            s3_r0_d = 25'(47'(s2_p_q) - 47'(t_d) * 47'(DQ));
        end
    end

    // S4: final conditional subtractions into [0, q).
    always_comb begin
        r_k   = s3_r0_q[13:0];
        r_d   = s3_r0_q;
        res_d = res_q;
        if (s3_mode_q == MODE_KYBER) begin
            if (r_k >= 14'(KQ)) r_k = r_k - 14'(KQ);
            res_d = {s3_ah_q, r_k[11:0]};
        end else begin
            if (r_d >= 25'(DQ)) r_d = r_d - 25'(DQ);
            if (r_d >= 25'(DQ)) r_d = r_d - 25'(DQ);
            res_d = {1'b0, r_d[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            mode_out_q  <= MODE_KYBER;
            res_q       <= '0;
        end else if (en) begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            out_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                mode_out_q <= s3_mode_q;
                res_q      <= res_d;
            end
        end
    end

    // NOTE: datapath registers carry no reset; the cleared valid bits already discard whatever they hold.
    always_ff @(posedge clk) begin
        if (en) begin
            if (in_valid) begin
                s1_mode_q <= mode_e'(mode_in);
                s1_a_q    <= a_in;
                s1_w_q    <= w_in[22:0];
            end
            if (s1_valid_q) begin
                s2_mode_q <= s1_mode_q;
                s2_p_q    <= s2_p_d;
                s2_ah_q   <= s1_a_q[23:12];
            end
            if (s2_valid_q) begin
                s3_mode_q <= s2_mode_q;
                s3_r0_q   <= s3_r0_d;
                s3_ah_q   <= s2_ah_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign mode_out  = mode_out_q;
    assign res       = res_q;

`ifdef MULT_RED_RANGE_CHECK_EN
    logic s2_oor_d, s2_oor_q, s3_oor_q, err_q;

    always_comb begin
        s2_oor_d = 1'b0;
        if (s1_mode_q == MODE_KYBER) begin
            s2_oor_d = (s1_a_q[11:0] >= 12'(KQ)) || (s1_w_q[11:0] >= 12'(KQ))
                    || (s1_a_q[23:12] >= 12'(KQ));
        end else begin
            s2_oor_d = (s1_a_q[22:0] >= 23'(DQ)) || (s1_w_q >= 23'(DQ));
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            if (s1_valid_q) s2_oor_q <= s2_oor_d;
            if (s2_valid_q) s3_oor_q <= s2_oor_q;
        end
    end

    // Sticky: rises together with the offending word's out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (en && s3_valid_q && s3_oor_q) begin
            err_q <= 1'b1;
        end
    end

    assign err_oor = err_q;
`endif

endmodule

// File: doc/mult_red_0.md
Name: mult_red_0

Overview:
- Pipelined modular multiplier/reducer sitting directly upstream of the butterfly adder stage.
- Kyber mode: multiplies the low 12-bit lane by a twiddle mod 3329, and delay-matches the high lane so the pair leaves together as a 24-bit {H, L} word.
- Dilithium mode: multiplies a 23-bit coefficient by a 23-bit twiddle mod 8380417, giving one 24-bit word.
- Output feeds the adder stage's 24-bit input directly.

Parameters:
- KQ, 3329, Kyber modulus
- DQ, 8380417, Dilithium modulus
- MU_K, 5039, floor(2^24/KQ), Kyber Barrett constant
- MU_D, 8396807, floor(2^46/DQ), Dilithium Barrett constant
- LAT, 4, fixed pipeline latency in enabled cycles (informative; not overridable)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  pipeline advance enable; 0 freezes all stages
- in_valid  input  1  a_in/w_in/mode_in valid this cycle
- mode_in  input  1  0 = Kyber, 1 = Dilithium; travels with its data
- a_in  input  24  Kyber: {AH[23:12], AL[11:0]}; Dilithium: a[22:0], bit 23 ignored
- w_in  input  24  Kyber: w[11:0], upper bits ignored; Dilithium: w[22:0]
- out_valid  output  1  res valid
- mode_out  output  1  mode of the word on res
- res  output  24  Kyber: {AH delayed, (AL*w) mod KQ}; Dilithium: {1'b0, (a*w) mod DQ}

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, mode_out=0, res=0, and all internal valid bits cleared. This takes priority over en. Words in flight are discarded; none are emitted after reset.
- Streaming with no backpressure. One word accepted per enabled cycle when in_valid=1.
- Each word appears on res with out_valid=1 exactly 4 enabled cycles after acceptance.
- Pipeline stages (all registers update only when en=1):
  - S1: register a, w, mode, valid.
  - S2: product. Kyber p = AL*w (24b). Dilithium p = a*w (46b). AH is carried alongside.
  - S3: quotient estimate. Kyber t = (p*MU_K)>>24. Dilithium t = (p*MU_D)>>46. Register r0 = p - t*q, with width q+2 bits.
  - S4: correction. Kyber: r0 in [0, 2KQ), one conditional subtract of KQ. Dilithium: r0 in [0, 3DQ), up to two conditional subtracts of DQ. Final result is always in [0, q).
- en=0: every register, including out_valid/res/mode_out, holds its value. in_valid is ignored (no acceptance). out_valid stays asserted if it was asserted.
- in_valid=0 while en=1: a bubble propagates. out_valid=0 four cycles later, and res holds its last valid value (data registers load only on a valid stage).
- Mode may change every cycle. Each word uses its own registered mode, with no flush and no mixing between adjacent words.
- Operand contract: Kyber AL, w < KQ; Dilithium a, w < DQ.
  - Out-of-range operands give a result that is unspecified but still < q.
  - The AH lane passes through unmodified regardless of range.
- Kyber mode: res[23:12] equals the AH accepted with that word, bit-exact.
- Dilithium mode: res[23] = 0.
- No combinational path from any input to any output.

Optional Feature:
- Macro MULT_RED_RANGE_CHECK_EN.
- Defined:
  - Adds output port err_oor (1 bit), reset to 0.
  - Set sticky when an accepted word violates the operand contract (Kyber AL >= KQ or w[11:0] >= KQ or AH >= KQ; Dilithium a[22:0] >= DQ or w[22:0] >= DQ).
  - Flag rises in the same cycle that word's out_valid rises.
  - Cleared only by rst.
- Undefined: port and check logic absent; behaviour otherwise identical.

Test Plan:
- Kyber: a_in={12'd100, 12'd3328}, w_in=3328, in_valid=1, en=1 -> 4 cycles later out_valid=1, res={12'd100, 12'd1}, mode_out=0.
- Dilithium: a_in=8380416, w_in=8380416 -> res=1. Next cycle a_in=2, w_in=3 -> res=6 on the following cycle. Back-to-back issue with no gaps.
- Alternating modes every cycle: Kyber {5,7}*w=9 then Dilithium 1000*1000 -> res {5,63} then 1000000, with mode_out tracking each word.
- Stall: issue 3 words, drop en for 5 cycles after the 2nd acceptance -> outputs frozen during the stall. All 3 words emerge in order, each exactly 4 enabled cycles after acceptance.
- Reset mid-flight: issue 3 words, assert rst for 1 cycle at cycle 2 -> out_valid=0, res=0. No stale word appears in the following 6 cycles.
- Random 10k words per mode, checked against a golden (a*w mod q) -> zero mismatches. With MULT_RED_RANGE_CHECK_EN, injecting AL=3329 -> err_oor=1 and sticky until rst.
